// File: rtl/ha_array_accumulator_pkg.sv
// Shared widths, state encoding and group-weight helper for the
// half-adder array accumulator.
package ha_array_pkg;

    localparam int B_W        = 7;
    localparam int T_W        = 9;
    localparam int P_W        = 16;
    localparam int ACC_W      = 17;
    localparam int NUM_GROUPS = 4;
    localparam int G_W        = 11;
    localparam int CNT_W      = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Group g sits 2g bit positions above group 0 in the final product.
    function automatic int group_shift(input int g);
        return 2 * g;
    endfunction

endpackage

// File: rtl/ha_array_accumulator_if.sv
// Operand/result handshake bundle between the multiplier front end and the
// accumulator. The master drives operands and accepts results.
interface ha_array_accumulator_if;
    import ha_array_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [B_W-1:0]   ha_array_0_b;
    logic [B_W-1:0]   ha_array_1_b;
    logic [B_W-1:0]   ha_array_2_b;
    logic [B_W-1:0]   ha_array_3_b;
    logic [T_W-1:0]   ha_array_0_t;
    logic [T_W-1:0]   ha_array_1_t;
    logic [T_W-1:0]   ha_array_2_t;
    logic [T_W-1:0]   ha_array_3_t;
    logic             out_valid;
    logic             out_ready;
    logic [P_W-1:0]   prod;
    logic             sat;
    logic             busy;

    modport master (
        output in_valid,
        output ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b,
        output ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t,
        output out_ready,
        input  in_ready, out_valid, prod, sat, busy
    );

    modport slave (
        input  in_valid,
        input  ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b,
        input  ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t,
        input  out_ready,
        output in_ready, out_valid, prod, sat, busy
    );

endinterface

// File: rtl/ha_array_accumulator_group.sv
// Value of one partial-product group: t row at weight i, b row at weight i+2.
module ha_group_value
    import ha_array_pkg::*;
(
    input  logic [B_W-1:0] i_b,
    input  logic [T_W-1:0] i_t,
    output logic [G_W-1:0] o_g
);

    // Max 511 + 508 = 1019, fits in G_W bits without overflow.
    assign o_g = G_W'(i_t) + (G_W'(i_b) << 2);

endmodule

// File: rtl/ha_array_accumulator.sv
// Sequential reducer: captures four ha_array groups, adds one weighted group
// per cycle, then presents a saturated 16-bit product until accepted.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand set
// ACC   | adding group r_cnt (0..3) into the accumulator
// DONE  | out_valid high, prod/sat held until out_ready
module ha_array_accumulator
    import ha_array_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    ha_array_accumulator_if.slave  bus
);

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [ACC_W-1:0]    r_acc;
    logic [B_W-1:0]      r_b [NUM_GROUPS];
    logic [T_W-1:0]      r_t [NUM_GROUPS];
    logic [P_W-1:0]      r_prod;
    logic                r_sat;

    logic                w_capture;
    logic                w_last;
    logic [B_W-1:0]      w_sel_b;
    logic [T_W-1:0]      w_sel_t;
    logic [G_W-1:0]      w_g;
    logic [ACC_W-1:0]    w_g_ext;
    logic [ACC_W-1:0]    w_term;
    logic [ACC_W-1:0]    w_acc_next;

    assign w_capture = (r_state == IDLE) && bus.in_valid;
    assign w_last    = (r_cnt == CNT_W'(NUM_GROUPS - 1));

    assign w_sel_b = r_b[r_cnt];
    assign w_sel_t = r_t[r_cnt];

    ha_group_value u_group_value (
        .i_b (w_sel_b),
        .i_t (w_sel_t),
        .o_g (w_g)
    );

    assign w_g_ext = ACC_W'(w_g);

    // Place the current group at its weight; a fixed mux keeps the shifter cheap.
    always_comb begin
        w_term = w_g_ext;
        case (r_cnt)
            2'd0:    w_term = w_g_ext << group_shift(0);
            2'd1:    w_term = w_g_ext << group_shift(1);
            2'd2:    w_term = w_g_ext << group_shift(2);
            2'd3:    w_term = w_g_ext << group_shift(3);
            default: w_term = w_g_ext;
        endcase
    end

    // Worst case 86615 < 2^17, so this add never wraps.
    assign w_acc_next = r_acc + w_term;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)  w_state_next = ACC;
            ACC:     if (w_last)        w_state_next = DONE;
            DONE:    if (bus.out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture, accumulation and registered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_prod <= '0;
            r_sat  <= 1'b0;
            for (int g = 0; g < NUM_GROUPS; g++) begin
                r_b[g] <= '0;
                r_t[g] <= '0;
            end
        end else if (w_capture) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_b[0] <= bus.ha_array_0_b;
            r_b[1] <= bus.ha_array_1_b;
            r_b[2] <= bus.ha_array_2_b;
            r_b[3] <= bus.ha_array_3_b;
            r_t[0] <= bus.ha_array_0_t;
            r_t[1] <= bus.ha_array_1_t;
            r_t[2] <= bus.ha_array_2_t;
            r_t[3] <= bus.ha_array_3_t;
        end else if (r_state == ACC) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                // Bit 16 set means the sum exceeded 16'hFFFF.
                r_prod <= w_acc_next[ACC_W-1] ? {P_W{1'b1}} : w_acc_next[P_W-1:0];
                r_sat  <= w_acc_next[ACC_W-1];
            end
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.prod      = r_prod;
    assign bus.sat       = r_sat;

endmodule

// File: tb/tb_ha_array_accumulator.sv
// Directed and random checks of the ha_array accumulator against a plain
// arithmetic model of the weighted group sum.
module tb_ha_array_accumulator;
    import ha_array_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   tb_b [4];
    int   tb_t [4];

    always #5 clk = ~clk;

    ha_array_accumulator_if bus ();

    ha_array_accumulator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Product of the multiplier: each group is t + 4b, group g weighted by 4^g.
    function automatic int ref_sum();
        int s;
        s = 0;
        for (int g = 0; g < 4; g++)
            s += (tb_t[g] + 4 * tb_b[g]) * (4 ** g);
        return s;
    endfunction

    task automatic clear_rows();
        for (int g = 0; g < 4; g++) begin
            tb_b[g] = 0;
            tb_t[g] = 0;
        end
    endtask

    task automatic apply_rows();
        bus.ha_array_0_b = 7'(tb_b[0]);
        bus.ha_array_1_b = 7'(tb_b[1]);
        bus.ha_array_2_b = 7'(tb_b[2]);
        bus.ha_array_3_b = 7'(tb_b[3]);
        bus.ha_array_0_t = 9'(tb_t[0]);
        bus.ha_array_1_t = 9'(tb_t[1]);
        bus.ha_array_2_t = 9'(tb_t[2]);
        bus.ha_array_3_t = 9'(tb_t[3]);
    endtask

    task automatic scramble_rows();
        bus.ha_array_0_b = 7'($urandom);
        bus.ha_array_1_b = 7'($urandom);
        bus.ha_array_2_b = 7'($urandom);
        bus.ha_array_3_b = 7'($urandom);
        bus.ha_array_0_t = 9'($urandom);
        bus.ha_array_1_t = 9'($urandom);
        bus.ha_array_2_t = 9'($urandom);
        bus.ha_array_3_t = 9'($urandom);
    endtask

    // Present tb rows until accepted; returns just after the capture edge.
    task automatic send(input string tag, input bit keep_valid);
        int n;
        n = 0;
        apply_rows();
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_accept"}, 32'(n < 20), 32'd1);
        @(posedge clk); #1;
        if (!keep_valid) begin
            bus.in_valid = 1'b0;
            scramble_rows();
        end
    endtask

    task automatic wait_result(input string tag);
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd4);
    endtask

    task automatic check_result(input string tag, input int exp_sum);
        check({tag, "_prod"}, 32'(bus.prod), (exp_sum > 65535) ? 32'hFFFF : 32'(exp_sum));
        check({tag, "_sat"}, 32'(bus.sat), 32'(exp_sum > 65535));
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    endtask

    task automatic release_result(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_drop_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input int exp_sum);
        send(tag, 1'b0);
        wait_result(tag);
        check_result(tag, exp_sum);
        release_result(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_a;
        int exp_b;
        int seen;

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        clear_rows();
        apply_rows();
        @(posedge clk); @(posedge clk); #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_prod", 32'(bus.prod), 32'd0);
        check("rst_sat", 32'(bus.sat), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        clear_rows(); tb_t[0] = 1;
        run_op("g0_t0", 1);

        clear_rows(); tb_t[1] = 1;
        run_op("g1_t0", 4);

        clear_rows(); tb_b[3] = 7'h40;
        run_op("g3_b6", 16384);

        // 0xFF * 0xFF = 0xFE01: group 3 carries 1016 (t=508, b=127), group 0 carries 1.
        clear_rows(); tb_t[0] = 1; tb_t[3] = 508; tb_b[3] = 127;
        run_op("ff_x_ff", 65025);

        for (int g = 0; g < 4; g++) begin
            tb_b[g] = 127;
            tb_t[g] = 511;
        end
        run_op("all_ones", 86615);

        // Back-to-back with in_valid held and result stalled in DONE.
        for (int g = 0; g < 4; g++) begin
            tb_b[g] = $urandom_range(0, 127);
            tb_t[g] = $urandom_range(0, 511);
        end
        exp_a = ref_sum();
        send("b2b_a", 1'b1);
        for (int g = 0; g < 4; g++) begin
            tb_b[g] = $urandom_range(0, 127);
            tb_t[g] = $urandom_range(0, 511);
        end
        exp_b = ref_sum();
        apply_rows();
        wait_result("b2b_a");
        for (int c = 0; c < 3; c++) begin
            check_result("b2b_hold", exp_a);
            check("b2b_hold_valid", 32'(bus.out_valid), 32'd1);
            @(posedge clk); #1;
        end
        check_result("b2b_a_final", exp_a);
        release_result("b2b_a");
        @(posedge clk); #1;
        check("b2b_b_busy", 32'(bus.busy), 32'd1);
        bus.in_valid = 1'b0;
        scramble_rows();
        wait_result("b2b_b");
        check_result("b2b_b", exp_b);
        release_result("b2b_b");

        // Reset in the second accumulate cycle aborts the operation.
        for (int g = 0; g < 4; g++) begin
            tb_b[g] = $urandom_range(1, 127);
            tb_t[g] = $urandom_range(1, 511);
        end
        send("abort", 1'b0);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_prod", 32'(bus.prod), 32'd0);
        check("abort_sat", 32'(bus.sat), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        check("abort_no_valid", 32'(seen), 32'd0);
        for (int g = 0; g < 4; g++) begin
            tb_b[g] = $urandom_range(0, 127);
            tb_t[g] = $urandom_range(0, 511);
        end
        run_op("post_rst", ref_sum());

        // Random operands, every third one biased toward saturation.
        for (int i = 0; i < 12; i++) begin
            for (int g = 0; g < 4; g++) begin
                if (i % 3 == 2) begin
                    tb_b[g] = $urandom_range(96, 127);
                    tb_t[g] = $urandom_range(400, 511);
                end else begin
                    tb_b[g] = $urandom_range(0, 127);
                    tb_t[g] = $urandom_range(0, 511);
                end
            end
            run_op($sformatf("rand%0d", i), ref_sum());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ha_array_accumulator.md
Name: ha_array_accumulator

Overview:
- Consumer end of the half-adder partial-product array interface. Takes the four ha_array groups produced by an unsigned 8x8 approximate multiplier front end; each group has a b row (7 bits) and a t row (9 bits).
- Reduces the four groups sequentially, one group per cycle, into the final product.
- Provides a valid/ready handshake on both sides and saturates the result to 16 bits.

Parameters:
- B_W, 7, width of each ha_array_g_b row.
- T_W, 9, width of each ha_array_g_t row.
- P_W, 16, output product width.
- ACC_W, 17, internal accumulator width (holds the worst-case sum of 86615).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  the ha_array rows are valid.
- in_ready  output  1  block can accept a new operand set.
- ha_array_0_b .. ha_array_3_b  input  7 each  b rows of groups 0..3.
- ha_array_0_t .. ha_array_3_t  input  9 each  t rows of groups 0..3.
- out_valid  output  1  prod/sat are valid.
- out_ready  input  1  downstream accepts the result.
- prod  output  16  reduced product, saturated.
- sat  output  1  the true sum exceeded 16'hFFFF.
- busy  output  1  state is not IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Weighting:
  - Group value G_g = t_g + (b_g << 2), so t[i] has weight i and b[i] has weight i+2.
  - Result = sum over g = 0..3 of (G_g << 2g).
  - Max G_g = 511 + 508 = 1019. Max total = 1019 x 85 = 86615 < 2^17, so the accumulator never wraps.
- Reset: state = IDLE; in_ready = 1; out_valid = 0; prod = 0; sat = 0; busy = 0; accumulator, group counter and capture registers = 0.
  - Reset asserted mid-operation aborts immediately.
  - The captured operand and any partial sum are discarded; no out_valid is produced for it.
- States:
  - IDLE:
    - in_ready = 1.
    - On in_valid & in_ready: capture all 8 rows, set acc = 0 and cnt = 0, go to ACC.
  - ACC:
    - in_ready = 0.
    - Each cycle: acc <= acc + (G_cnt << 2cnt), cnt <= cnt + 1.
    - After cnt = 3 is added, go to DONE.
  - DONE:
    - out_valid = 1.
    - prod = (acc > 16'hFFFF) ? 16'hFFFF : acc[15:0]; sat = acc[16].
    - Hold prod, sat and out_valid stable while out_ready = 0.
    - On out_ready, go to IDLE next cycle; out_valid drops.
- Latency: handshake at edge E0, groups added on E1..E4, out_valid high after E4 (4 cycles).
- Throughput: one result per 6 cycles minimum (IDLE, 4 x ACC, DONE).
- in_ready is never high outside IDLE. Input changes after capture have no effect on the result.
- prod and sat are registered outputs. Their values outside DONE are don't-care to downstream, but must not be X after reset.
- in_valid high during ACC or DONE is ignored. The source must hold it until in_ready.
- out_ready high outside DONE is ignored.
- cnt is 2 bits. No wrap is reachable, because the transition to DONE happens at cnt = 3.

Decomposition:
- Shared package ha_array_pkg:
  - B_W, T_W, P_W, ACC_W, NUM_GROUPS = 4.
  - State enum {IDLE, ACC, DONE}.
  - Function group_shift(g) = 2g.
- Sub-module ha_group_value: combinational t + (b << 2) producing an 11-bit G. The top module shifts G by 2cnt via a mux.

Test Plan:
1. Group 0 t = 9'h001, all other rows 0 -> prod = 16'h0001, sat = 0, out_valid 4 cycles after the handshake.
2. Group 1 t = 9'h001 only -> prod = 4. Group 3 b[6] = 1 only (weight 14) -> prod = 16'h4000.
3. Rows of an exact 8x8 product: x = 8'hFF, y = 8'hFF, rows generated with full half-adders -> prod = 16'hFE01, sat = 0.
4. All t = 9'h1FF and all b = 7'h7F -> acc = 86615, prod = 16'hFFFF, sat = 1.
5. Back-to-back in_valid held high, out_ready held low 3 cycles in DONE:
   - prod, sat and out_valid stay stable; in_ready = 0 throughout.
   - Second operand is captured only in IDLE after out_ready.
6. Assert rst during the second ACC cycle -> all outputs return to reset values asynchronously and no out_valid appears. A new operand after reset is computed correctly.
